button_event_arbiter: RTL

//  Conditions N push-button inputs and converts each press into one queued event.
//  Per channel: 2-FF synchroniser, optional debounce, rising-edge detect, pending flag.
//  A round-robin arbiter serialises pending events onto one valid/ready stream.

---
 rtl/button_event_arbiter_if.sv | 11 +
 rtl/button_event_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter_if.sv
// Event stream between the button arbiter (master) and its consumer (slave).
interface button_event_arbiter_if #(
   parameter int unsigned ID_W = 2
);
   logic            evt_valid;
   logic            evt_ready;
   logic [ID_W-1:0] evt_id;

   modport master (output evt_valid, output evt_id, input evt_ready);
   modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// N push-buttons -> synchronised, edge-detected, pending-flagged events serialised round-robin.
// Define BTN_DEBOUNCE_EN to insert a per-channel stable-count debouncer after the synchroniser.
module button_event_arbiter #(
   parameter int unsigned N_BTN      = 4,
   parameter int unsigned DB_CYCLES  = 50000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_BTN-1:0]      btn_raw,
   button_event_arbiter_if.master evt,
   output logic [N_BTN-1:0]      pending,
   output logic                  overrun
);
   localparam int unsigned ID_W = $clog2(N_BTN);
   localparam int unsigned IdxW = ID_W + 1;

   if (N_BTN < 2 || N_BTN > 16 || DB_CYCLES == 0) begin : g_param_check
      $error("button_event_arbiter: unsupported N_BTN or DB_CYCLES");
   end

   typedef enum logic [0:0] {StIdle, StOffer} state_e;

   logic [N_BTN-1:0] raw_pressed, sync1_q, sync2_q, lvl, lvl_d_q, press_q;
   logic [N_BTN-1:0] pending_q, pending_d, clr;
   logic             overrun_q, overrun_d, accept;
   state_e           state_q, state_d;
   logic [ID_W-1:0]  id_q, id_d, ptr_q, ptr_d, pick;
   logic [IdxW-1:0]  rr_idx;
   logic             found;

   assign raw_pressed = ACTIVE_LOW ? ~btn_raw : btn_raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_d_q <= '0;
         press_q <= '0;
      end else begin
         sync1_q <= raw_pressed;
         sync2_q <= sync1_q;
         lvl_d_q <= lvl;
         press_q <= lvl & ~lvl_d_q;
      end
   end

`ifdef BTN_DEBOUNCE_EN
   localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
   logic [CntW-1:0]  cnt_q [N_BTN];
   logic [N_BTN-1:0] lvl_q;

   // Level follows the synced input only after DB_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q <= '0;
         for (int i = 0; i < int'(N_BTN); i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(N_BTN); i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
               if (cnt_q[i] == CntW'(DB_CYCLES - 1)) begin
                  lvl_q[i] <= sync2_q[i];
                  cnt_q[i] <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end
   assign lvl = lvl_q;
`else
   assign lvl = sync2_q;
`endif

   assign accept = (state_q == StOffer) && evt.evt_ready;

   // A fresh press on the channel being accepted re-arms it rather than counting as overrun.
   always_comb begin
      clr       = accept ? (N_BTN'(1) << id_q) : '0;
      pending_d = (pending_q & ~clr) | press_q;
      overrun_d = |(press_q & pending_q & ~clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign pending = pending_q;
   assign overrun = overrun_q;

   always_comb begin
      pick   = '0;
      found  = 1'b0;
      rr_idx = '0;
      for (int k = 0; k < int'(N_BTN); k++) begin
         rr_idx = {1'b0, ptr_q} + IdxW'(k);
         if (rr_idx >= IdxW'(N_BTN)) rr_idx = rr_idx - IdxW'(N_BTN);
         if (!found && pending_q[rr_idx[ID_W-1:0]]) begin
            found = 1'b1;
            pick  = rr_idx[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         id_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StOffer;
               id_d    = pick;
            end
         end
         StOffer: begin
            if (evt.evt_ready) begin
               state_d = StIdle;
               ptr_d   = (id_q == ID_W'(N_BTN - 1)) ? '0 : id_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      evt.evt_valid = (state_q == StOffer);
      evt.evt_id    = id_q;
   end
endmodule
